dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder serving the load/store side of the rv32 pipeline over a valid/ready request/response handshake. It accepts one word-addressed request at a time and applies per-byte write enables. After a programmable number of wait states it returns read data, or an error flag for a null byte mask. It is the memory end of the core's data port and replaces the zero-latency combinational data memory when realistic memory timing is needed.

## Interface
- AW, 10, word-address width; memory depth is 2^AW 32-bit words
- LAT, 2, wait states between request accept and access; legal range 0..15

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_be  in  4  byte enables; bit i selects bits [8i+7:8i]
- req_addr  in  AW  word address
- req_wdata  in  32  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  32  word read at the addressed location
- rsp_err  out  1  request had req_be == 0
- busy  out  1  high in WAIT and RESP

## Operation
- FSM states and behaviour:
  - IDLE: req_ready=1, busy=0.
  - WAIT: req_ready=0, busy=1.
  - RESP: req_ready=0, busy=1, rsp_valid=1.
- Accept: in IDLE with req_valid=1 at a rising edge, latch we, be, addr and wdata, then load the wait counter with LAT.
  - LAT>0: go to WAIT.
  - LAT=0: perform the access on that same edge and go to RESP.
- WAIT: the counter decrements each edge. On the edge where the counter is 1, perform the access and go to RESP.
- Access:
  - rsp_rdata is loaded with mem[addr] as it was before the access. For a store this means the old word.
  - Store: for each set bit of be, mem[addr] byte i is replaced by wdata byte i. Bytes with a clear be bit are unchanged.
- Error: if the latched be is 0000, there is no memory access, rsp_rdata=0 and rsp_err=1. Timing is identical to a normal access.
- RESP: rsp_valid, rsp_rdata and rsp_err hold stable until an edge with rsp_ready=1. On that edge rsp_valid and rsp_err clear, rsp_rdata holds, and the FSM returns to IDLE.
- Only one request is outstanding at a time. A new request cannot be accepted on the response-handshake edge; req_ready rises in the following cycle.
- Address arithmetic: AW bits only, no out-of-range detection. Byte lanes never carry between words.
- Memory contents are not cleared by reset and are X until written.

## Timing
- While reset=0, all state is forced immediately (asynchronously), independent of clk:
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0.
  - req_ready is gated low while reset is asserted. It goes to 1 in the first cycle after release.
- Latency: with the request accepted at edge N, rsp_valid is high from just after edge N+LAT. A LAT=0 request therefore responds in the next cycle.
- Throughput with rsp_ready tied high is one request per LAT+2 cycles.
- Reset asserted mid-operation (WAIT or RESP):
  - The pending request is discarded; a store not yet performed never reaches memory.
  - Stores already performed remain.
- If req_valid and rsp_ready change while not in IDLE or RESP respectively, they are ignored.
- All outputs are registered except req_ready, which is decoded from state and gated by reset.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles.
  - Required: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and req_ready=0 while reset is asserted; req_ready=1 in the first cycle after release.
- Store then load at LAT=2:
  - Store addr=0x005, be=1111, wdata=0xDEADBEEF. Required: rsp_valid goes high 2 cycles after accept.
  - Load addr=0x005. Required: rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial store: with mem[0x005]=0xDEADBEEF, store be=0101, wdata=0x11223344.
  - Required: the store response returns 0xDEADBEEF; a following load returns 0xDE22BE44.
- Backpressure and null mask:
  - Load with rsp_ready=0 for 5 cycles. Required: rsp_valid and rsp_rdata stay stable, req_ready stays 0 and a second req_valid is ignored; after rsp_ready=1, req_ready=1 one cycle later.
  - Store with be=0000. Required: rsp_err=1, rsp_rdata=0, memory unchanged.
- Reset mid-operation: accept a store to 0x010 (wdata 0xCAFEF00D) and assert reset during WAIT.
  - Required: after release, a load of 0x010 returns the prior value, not 0xCAFEF00D.
- LAT=0 build with back-to-back loads and rsp_ready tied high:
  - Required: responses on alternate cycles, each load's response arriving in the cycle after its accept.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data-memory responder with valid/ready request and
// response handshakes and a programmable number of wait states.
//
// Parameters
//   AW  : word-address width, memory depth is 2**AW 32-bit words
//   LAT : wait states between request accept and access (0..15)
//
// Ports
//   clk        : clock, rising-edge active
//   reset      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder can accept a request (IDLE, gated by reset)
//   req_we     : 1 = store, 0 = load
//   req_be     : byte enables, bit i selects bits [8i+7:8i]
//   req_addr   : word address
//   req_wdata  : store data
//   rsp_valid  : response present
//   rsp_ready  : requester takes the response
//   rsp_rdata  : word at the addressed location before the access
//   rsp_err    : request carried an all-zero byte mask
//   busy       : high in WAIT and RESP
module dmem_resp #(
   parameter int unsigned AW  = 10,
   parameter int unsigned LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [3:0]    req_be,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          busy
);

   localparam int unsigned DEPTH   = 1 << AW;
   localparam logic [3:0]  LAT_CNT = 4'(LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic [3:0]    be_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;

   logic [31:0]   mem [DEPTH];

   logic          access;
   logic          acc_we;
   logic [3:0]    acc_be;
   logic [AW-1:0] acc_addr;
   logic [31:0]   acc_wdata;
   logic          null_mask;
   logic [31:0]   rd_word;

   assign req_ready = reset && (state == IDLE);

   // With LAT=0 the access happens on the accept edge itself, so it must use
   // the live request fields rather than the latched copies.
   always_comb begin
      access    = 1'b0;
      acc_we    = we_q;
      acc_be    = be_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_be    = req_be;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         access    = reset && req_valid && (LAT == 0);
      end else if (state == WAIT) begin
         access    = reset && (cnt == 4'd1);
      end
      null_mask = (acc_be == 4'b0000);
      rd_word   = null_mask ? '0 : mem[acc_addr];
   end

   // Memory array has no reset; contents survive reset assertion.
   always_ff @(posedge clk) begin
      if (access && acc_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (acc_be[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  be_q    <= req_be;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cnt     <= LAT_CNT;
                  busy    <= 1'b1;
                  if (LAT == 0) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rd_word;
                     rsp_err   <= null_mask;
                     state     <= RESP;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_word;
                  rsp_err   <= null_mask;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

   logic        clk;
   logic        reset;

   // LAT=2 instance
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_be;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;

   // LAT=0 instance
   logic        req_valid0, req_ready0, req_we0;
   logic [3:0]  req_be0;
   logic [9:0]  req_addr0;
   logic [31:0] req_wdata0;
   logic        rsp_valid0, rsp_ready0, rsp_err0, busy0;
   logic [31:0] rsp_rdata0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        er;

   dmem_resp #(.AW(10), .LAT(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   dmem_resp #(.AW(10), .LAT(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_be(req_be0), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
      .rsp_err(rsp_err0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full LAT=2 transaction: accept, latency check, handshake.
   task automatic txn(input string tag, input logic we, input logic [3:0] be,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdo, output logic erro);
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
      tick();                                       // accept edge N
      req_valid = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();                                       // edge N+1
      check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
      tick();                                       // edge N+2
      check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      rdo  = rsp_rdata;
      erro = rsp_err;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 0; req_we = 0; req_be = '0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
      req_valid0 = 0; req_we0 = 0; req_be0 = '0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1;

      // Reset held for 3 cycles
      tick(); tick(); tick();
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_ready", {31'd0, req_ready}, 32'd1);
      tick();

      // Store then load at LAT=2
      txn("st_full", 1'b1, 4'b1111, 10'h005, 32'hDEADBEEF, rd, er);
      check("st_full_err", {31'd0, er}, 32'd0);
      txn("ld_full", 1'b0, 4'b1111, 10'h005, 32'h0, rd, er);
      check("ld_full_data", rd, 32'hDEADBEEF);
      check("ld_full_err", {31'd0, er}, 32'd0);

      // Partial store returns the old word
      txn("st_part", 1'b1, 4'b0101, 10'h005, 32'h11223344, rd, er);
      check("st_part_old", rd, 32'hDEADBEEF);
      txn("ld_part", 1'b0, 4'b1111, 10'h005, 32'h0, rd, er);
      check("ld_part_data", rd, 32'hDE22BE44);

      // Backpressure: response held, competing store request ignored
      req_valid = 1'b1; req_we = 1'b0; req_be = 4'b1111; req_addr = 10'h005;
      tick();
      req_we = 1'b1; req_wdata = 32'h0BADBAD0;      // would corrupt if accepted
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rdata", rsp_rdata, 32'hDE22BE44);
         check("bp_rdy", {31'd0, req_ready}, 32'd0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_done", {31'd0, rsp_valid}, 32'd0);
      check("bp_hold", rsp_rdata, 32'hDE22BE44);
      check("bp_rdy_after", {31'd0, req_ready}, 32'd1);
      txn("bp_ld", 1'b0, 4'b1111, 10'h005, 32'h0, rd, er);
      check("bp_mem", rd, 32'hDE22BE44);

      // Null byte mask
      txn("null", 1'b1, 4'b0000, 10'h005, 32'hFFFFFFFF, rd, er);
      check("null_err", {31'd0, er}, 32'd1);
      check("null_rdata", rd, 32'd0);
      txn("null_ld", 1'b0, 4'b1111, 10'h005, 32'h0, rd, er);
      check("null_mem", rd, 32'hDE22BE44);
      check("null_ld_err", {31'd0, er}, 32'd0);

      // Reset during WAIT discards a pending store
      txn("pre10", 1'b1, 4'b1111, 10'h010, 32'h12345678, rd, er);
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'b1111; req_addr = 10'h010; req_wdata = 32'hCAFEF00D;
      tick();                                       // accepted, now in WAIT
      req_valid = 1'b0;
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid_async_busy", {31'd0, busy}, 32'd0);
      check("mid_async_rdy", {31'd0, req_ready}, 32'd0);
      tick(); tick(); tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      txn("mid_ld", 1'b0, 4'b1111, 10'h010, 32'h0, rd, er);
      check("mid_mem", rd, 32'h12345678);

      // LAT=0 back-to-back with rsp_ready tied high
      req_valid0 = 1'b1; req_we0 = 1'b1; req_be0 = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         req_addr0 = 10'(i + 1); req_wdata0 = 32'(32'hA0 + i);
         check("b2b_st_rdy", {31'd0, req_ready0}, 32'd1);
         tick();
         check("b2b_st_valid", {31'd0, rsp_valid0}, 32'd1);
         check("b2b_st_busy_rdy", {31'd0, req_ready0}, 32'd0);
         tick();
         check("b2b_st_gap", {31'd0, rsp_valid0}, 32'd0);
      end
      req_we0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_addr0 = 10'(i + 1);
         tick();
         check("b2b_ld_valid", {31'd0, rsp_valid0}, 32'd1);
         check("b2b_ld_data", rsp_rdata0, 32'(32'hA0 + i));
         check("b2b_ld_err", {31'd0, rsp_err0}, 32'd0);
         tick();
         check("b2b_ld_gap", {31'd0, rsp_valid0}, 32'd0);
      end
      req_valid0 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
